// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: shared widths, queue entry layouts,
// AXI response codes and AXI master FSM states.
package apb2axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_entry_t;

  typedef struct packed {
    logic              is_write;
    logic [1:0]        resp;
    logic [DATA_W-1:0] rdata;
  } rsp_entry_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    AXM_IDLE,
    AXM_WR_REQ,
    AXM_WR_B,
    AXM_RD_AR,
    AXM_RD_R,
    AXM_RSP
  } axm_state_t;

endpackage

// File: rtl/apb2axi_axi_master.sv
// apb2axi_axi_master: pops one request entry, runs it as a
// single AXI4-Lite write or read, pushes one response entry.
import apb2axi_pkg::*;

module apb2axi_axi_master #(
  parameter int ADDR_W = apb2axi_pkg::ADDR_W,
  parameter int DATA_W = apb2axi_pkg::DATA_W,
  parameter int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8,
  parameter int RSP_W  = 3 + DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_vld,
  output logic                req_rdy,
  input  logic [REQ_W-1:0]    req_data,
  output logic                rsp_vld,
  input  logic                rsp_rdy,
  output logic [RSP_W-1:0]    rsp_data,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp
);

  axm_state_t state;
  axm_state_t state_nxt;
  req_entry_t req;
  rsp_entry_t rsp_q;
  logic       aw_done;
  logic       w_done;
  logic       aw_ok;
  logic       w_ok;

  assign req      = req_data;
  assign rsp_data = rsp_q;
  assign req_rdy  = (state == AXM_IDLE) && !reset;

  // a channel counts as done if it already fired or fires now
  assign aw_ok = aw_done || (awvalid && awready);
  assign w_ok  = w_done  || (wvalid && wready);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= AXM_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      AXM_IDLE:
        if (req_vld && req_rdy)
          state_nxt = req.is_write ? AXM_WR_REQ : AXM_RD_AR;
      AXM_WR_REQ:
        if (aw_ok && w_ok) state_nxt = AXM_WR_B;
      AXM_WR_B:
        if (bvalid) state_nxt = AXM_RSP;
      AXM_RD_AR:
        if (arready) state_nxt = AXM_RD_R;
      AXM_RD_R:
        if (rvalid) state_nxt = AXM_RSP;
      AXM_RSP:
        if (rsp_rdy) state_nxt = AXM_IDLE;
      default:
        state_nxt = AXM_IDLE;
    endcase
  end

  // registered AXI / response outputs, set up one cycle ahead
  always_ff @(posedge clk) begin
    if (reset) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      arvalid <= 1'b0;
      bready  <= 1'b0;
      rready  <= 1'b0;
      rsp_vld <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
      araddr  <= '0;
      rsp_q   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      unique case (state)
        AXM_IDLE: begin
          if (req_vld) begin
            if (req.is_write) begin
              awaddr  <= req.addr;
              wdata   <= req.wdata;
              wstrb   <= req.wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              araddr  <= req.addr;
              arvalid <= 1'b1;
            end
          end
        end
        AXM_WR_REQ: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_ok && w_ok) bready <= 1'b1;
        end
        AXM_WR_B: begin
          if (bvalid) begin
            bready         <= 1'b0;
            rsp_vld        <= 1'b1;
            rsp_q.is_write <= 1'b1;
            rsp_q.resp     <= bresp;
            rsp_q.rdata    <= '0;
          end
        end
        AXM_RD_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        AXM_RD_R: begin
          if (rvalid) begin
            rready         <= 1'b0;
            rsp_vld        <= 1'b1;
            rsp_q.is_write <= 1'b0;
            rsp_q.resp     <= rresp;
            rsp_q.rdata    <= rdata;
          end
        end
        AXM_RSP: begin
          if (rsp_rdy) rsp_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb2axi_axi_master.sv
// tb_apb2axi_axi_master: directed vectors with hand-computed
// expectations for the AXI4-Lite request executor.
module tb_apb2axi_axi_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_vld;
  logic        req_rdy;
  logic [68:0] req_data;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [34:0] rsp_data;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int errors = 0;
  int checks = 0;
  int pushes = 0;
  int base;
  logic [34:0] held;

  apb2axi_axi_master dut (
    .clk(clk), .reset(reset),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_data(req_data),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_data(rsp_data),
    .awvalid(awvalid), .awready(awready),
    .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready),
    .bresp(bresp),
    .arvalid(arvalid), .arready(arready),
    .araddr(araddr),
    .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && rsp_vld && rsp_rdy) pushes <= pushes + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    req_vld  = 1'b0;
    req_data = '0;
    rsp_rdy  = 1'b1;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    bresp    = 2'b00;
    arready  = 1'b0;
    rvalid   = 1'b0;
    rdata    = '0;
    rresp    = 2'b00;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".vld"}, 64'({awvalid, wvalid, arvalid,
                            bready, rready, rsp_vld}), 64'd0);
    chk({tag, ".awaddr"}, 64'(awaddr), 64'd0);
    chk({tag, ".wdata"}, 64'(wdata), 64'd0);
    chk({tag, ".wstrb"}, 64'(wstrb), 64'd0);
    chk({tag, ".araddr"}, 64'(araddr), 64'd0);
    chk({tag, ".rsp_data"}, 64'(rsp_data), 64'd0);
  endtask

  initial begin
    idle_bus();
    reset = 1'b1;
    step();
    step();
    chk("rst.req_rdy", 64'(req_rdy), 64'd0);
    chk_reset_outs("rst");
    reset = 1'b0;
    #1;
    chk("rst.rel_req_rdy", 64'(req_rdy), 64'd1);

    // single write, all readies high
    base     = pushes;
    req_vld  = 1'b1;
    req_data = {1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF};
    awready  = 1'b1;
    wready   = 1'b1;
    bvalid   = 1'b1;
    bresp    = 2'b00;
    step();
    req_vld = 1'b0;
    chk("w1.awvalid", 64'(awvalid), 64'd1);
    chk("w1.wvalid", 64'(wvalid), 64'd1);
    chk("w1.awaddr", 64'(awaddr), 64'h1000_0040);
    chk("w1.wdata", 64'(wdata), 64'hDEAD_BEEF);
    chk("w1.wstrb", 64'(wstrb), 64'hF);
    chk("w1.req_rdy", 64'(req_rdy), 64'd0);
    step();
    chk("w1.avw_low", 64'({awvalid, wvalid}), 64'd0);
    chk("w1.bready", 64'(bready), 64'd1);
    step();
    chk("w1.bready_low", 64'(bready), 64'd0);
    chk("w1.rsp_vld", 64'(rsp_vld), 64'd1);
    chk("w1.rsp_data", 64'(rsp_data),
        64'({1'b1, 2'b00, 32'h0}));
    step();
    chk("w1.rsp_vld_low", 64'(rsp_vld), 64'd0);
    chk("w1.req_rdy_again", 64'(req_rdy), 64'd1);
    chk("w1.pushes", 64'(pushes - base), 64'd1);

    // write, awready delayed 3 cycles, wready immediate
    idle_bus();
    base     = pushes;
    req_vld  = 1'b1;
    req_data = {1'b1, 32'h3000_0004, 32'h0BAD_F00D, 4'h3};
    wready   = 1'b1;
    step();
    req_vld = 1'b0;
    chk("w2.c1_valids", 64'({awvalid, wvalid}), 64'b11);
    step();
    chk("w2.c2_valids", 64'({awvalid, wvalid}), 64'b10);
    chk("w2.c2_bready", 64'(bready), 64'd0);
    step();
    chk("w2.c3_aw", 64'(awvalid), 64'd1);
    chk("w2.c3_bready", 64'(bready), 64'd0);
    chk("w2.awaddr", 64'(awaddr), 64'h3000_0004);
    step();
    chk("w2.c4_aw", 64'(awvalid), 64'd1);
    awready = 1'b1;
    step();
    chk("w2.c5_aw", 64'(awvalid), 64'd0);
    chk("w2.c5_bready", 64'(bready), 64'd1);
    bvalid = 1'b1;
    bresp  = 2'b01;
    step();
    bvalid = 1'b0;
    chk("w2.rsp_data", 64'(rsp_data),
        64'({1'b1, 2'b01, 32'h0}));
    step();
    chk("w2.pushes", 64'(pushes - base), 64'd1);

    // read, rvalid delayed 5 cycles, SLVERR, rsp_rdy held low
    idle_bus();
    base     = pushes;
    req_vld  = 1'b1;
    req_data = {1'b0, 32'h2000_0000, 32'h0, 4'h0};
    arready  = 1'b1;
    step();
    req_vld = 1'b0;
    chk("r1.arvalid", 64'(arvalid), 64'd1);
    chk("r1.araddr", 64'(araddr), 64'h2000_0000);
    step();
    chk("r1.arvalid_low", 64'(arvalid), 64'd0);
    chk("r1.rready", 64'(rready), 64'd1);
    for (int i = 0; i < 4; i++) step();
    chk("r1.rready_wait", 64'(rready), 64'd1);
    chk("r1.no_rsp", 64'(rsp_vld), 64'd0);
    rvalid  = 1'b1;
    rdata   = 32'h1234_5678;
    rresp   = 2'b10;
    rsp_rdy = 1'b0;
    step();
    rvalid   = 1'b0;
    rdata    = 32'hFFFF_FFFF;
    req_vld  = 1'b1;
    req_data = {1'b1, 32'h0000_0040, 32'h55AA_55AA, 4'hF};
    awready  = 1'b1;
    wready   = 1'b1;
    chk("r1.rready_low", 64'(rready), 64'd0);
    chk("r1.rsp_data", 64'(rsp_data),
        64'({1'b0, 2'b10, 32'h1234_5678}));
    held = 35'({1'b0, 2'b10, 32'h1234_5678});
    for (int i = 0; i < 4; i++) begin
      chk("hold.rsp_vld", 64'(rsp_vld), 64'd1);
      chk("hold.rsp_data", 64'(rsp_data), 64'(held));
      chk("hold.req_rdy", 64'(req_rdy), 64'd0);
      if (i < 3) step();
    end
    rsp_rdy = 1'b1;
    step();
    chk("hold.pushes", 64'(pushes - base), 64'd1);
    chk("hold.req_rdy_after", 64'(req_rdy), 64'd1);

    // next write accepted, then reset while in WR_B
    step();
    req_vld = 1'b0;
    chk("rw.awaddr", 64'(awaddr), 64'h0000_0040);
    chk("rw.wdata", 64'(wdata), 64'h55AA_55AA);
    step();
    chk("rw.bready", 64'(bready), 64'd1);
    step();
    chk("rw.still_wrb", 64'(bready), 64'd1);
    base  = pushes;
    reset = 1'b1;
    step();
    chk("rw.req_rdy", 64'(req_rdy), 64'd0);
    chk_reset_outs("rw");
    reset = 1'b0;
    #1;
    chk("rw.idle", 64'(req_rdy), 64'd1);

    // read after reset, all readies high
    idle_bus();
    req_vld  = 1'b1;
    req_data = {1'b0, 32'h2000_0008, 32'h0, 4'h0};
    arready  = 1'b1;
    rvalid   = 1'b1;
    rdata    = 32'hCAFE_F00D;
    rresp    = 2'b00;
    step();
    req_vld = 1'b0;
    chk("r2.araddr", 64'(araddr), 64'h2000_0008);
    chk("r2.arvalid", 64'(arvalid), 64'd1);
    step();
    chk("r2.rready", 64'(rready), 64'd1);
    step();
    chk("r2.rsp_data", 64'(rsp_data),
        64'({1'b0, 2'b00, 32'hCAFE_F00D}));
    step();
    chk("r2.req_rdy", 64'(req_rdy), 64'd1);
    chk("r2.pushes", 64'(pushes - base), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
